// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer_if
// Purpose  : Bundles the command, ALU-drive and response signals of the
//            ALU op sequencer. "slave" is the sequencer's view; "master" is
//            the view of the block that drives commands, hosts the ALU and
//            consumes responses.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if #(
  parameter int WIDTH = 8
);
  // command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_cin;
  // ALU drive / result
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_out;
  logic             alu_ovf;
  // response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_ovf;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin,
    output cmd_ready,
    output alu_a, alu_b, alu_sel, alu_cin,
    input  alu_out, alu_ovf,
    output rsp_valid, rsp_data, rsp_ovf,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel, alu_cin,
    output alu_out, alu_ovf,
    input  rsp_valid, rsp_data, rsp_ovf,
    output rsp_ready
  );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Single-command front-end for an 8-bit combinational ALU. Latches
//            a command into registered ALU inputs, iterates one-bit shifts to
//            reach multi-bit counts, captures result/overflow and holds them
//            on a valid/ready response port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 3
) (
  input wire               clock,
  input wire               clear_n,
  alu_op_sequencer_if.slave bus
);

  localparam logic [2:0]      OP_ADD  = 3'b000;
  localparam logic [2:0]      OP_SUB  = 3'b001;
  localparam logic [2:0]      OP_SHL  = 3'b110;
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] alu_a_q,    alu_a_d;
  logic [WIDTH-1:0] alu_b_q,    alu_b_d;
  logic [2:0]       alu_sel_q,  alu_sel_d;
  logic             alu_cin_q,  alu_cin_d;
  logic [CNTW-1:0]  cnt_q,      cnt_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_ovf_q,  rsp_ovf_d;

  logic [CNTW-1:0]  cmd_cnt;
  logic             cmd_is_shift;
  logic             sel_is_arith;
  logic             shift_out;

  assign cmd_cnt      = bus.cmd_b[CNTW-1:0];
  assign cmd_is_shift = (bus.cmd_op[2:1] == 2'b11);
  // The ALU's flag output is undefined for logic ops, so only add/sub pass it.
  assign sel_is_arith = (alu_sel_q == OP_ADD) || (alu_sel_q == OP_SUB);
  // Bit that falls off the operand during the current one-bit shift step.
  assign shift_out    = (alu_sel_q == OP_SHL) ? alu_a_q[WIDTH-1] : alu_a_q[0];

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.alu_cin   = alu_cin_q;

  // Next-state and datapath updates for the command/shift/response sequence.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    alu_cin_d  = alu_cin_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_ovf_d  = rsp_ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          alu_a_d   = bus.cmd_a;
          alu_b_d   = bus.cmd_b;
          alu_sel_d = bus.cmd_op;
          alu_cin_d = bus.cmd_cin;
          rsp_ovf_d = 1'b0;
          if (!cmd_is_shift) begin
            state_d = EXEC;
          end else if (cmd_cnt != '0) begin
            cnt_d   = cmd_cnt;
            state_d = SHIFT;
          end else begin
            // Zero-length shift: the operand is the answer, no ALU pass needed.
            rsp_data_d = bus.cmd_a;
            state_d    = RESP;
          end
        end
      end
      EXEC: begin
        rsp_data_d = bus.alu_out;
        rsp_ovf_d  = sel_is_arith ? bus.alu_ovf : 1'b0;
        state_d    = RESP;
      end
      SHIFT: begin
        // Feed the one-bit result back as the next operand.
        alu_a_d   = bus.alu_out;
        rsp_ovf_d = rsp_ovf_q | shift_out;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          rsp_data_d = bus.alu_out;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight command.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= 3'b000;
      alu_cin_q  <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      alu_cin_q  <= alu_cin_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_ovf_q  <= rsp_ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Self-checking bench for alu_op_sequencer: hosts a one-step ALU,
//            keeps a transaction-level reference model, runs directed
//            literal cases and a randomized traffic phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;
  localparam int W = 8;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;
  logic junk    = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  always #5 clock = ~clock;

  alu_op_sequencer_if #(.WIDTH(W)) bus ();

  alu_op_sequencer #(.WIDTH(W), .CNTW(3)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  // One-step ALU: flag is garbage for non-arithmetic ops.
  logic [W:0] alu_sum;
  always_comb begin
    alu_sum     = '0;
    bus.alu_out = '0;
    bus.alu_ovf = junk;
    case (bus.alu_sel)
      3'd0: begin
        alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {{W{1'b0}}, bus.alu_cin};
        bus.alu_out = alu_sum[W-1:0];
        bus.alu_ovf = alu_sum[W];
      end
      3'd1: begin
        alu_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        bus.alu_out = alu_sum[W-1:0];
        bus.alu_ovf = alu_sum[W];
      end
      3'd2: bus.alu_out = bus.alu_a & bus.alu_b;
      3'd3: bus.alu_out = bus.alu_a | bus.alu_b;
      3'd4: bus.alu_out = bus.alu_a ^ bus.alu_b;
      3'd5: bus.alu_out = ~bus.alu_a;
      3'd6: bus.alu_out = bus.alu_a << 1;
      default: bus.alu_out = bus.alu_a >> 1;
    endcase
  end

  initial forever begin
    @(negedge clock);
    junk = 1'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-command result from plain arithmetic.
  function automatic void model_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                    input logic cin, output logic [7:0] d, output logic o,
                                    output int lat);
    int n;
    int s;
    n   = int'(b[2:0]);
    lat = 2;
    o   = 1'b0;
    s   = 0;
    case (op)
      3'd0: begin s = int'(a) + int'(b) + int'(cin); d = s[7:0]; o = (s > 255); end
      3'd1: begin s = int'(a) - int'(b); d = s[7:0]; o = (a < b); end
      3'd2: d = a & b;
      3'd3: d = a | b;
      3'd4: d = a ^ b;
      3'd5: d = ~a;
      3'd6: begin s = int'(a) << n; d = s[7:0]; o = (s > 255); lat = n + 1; end
      default: begin d = a >> n; o = ((int'(a) & ((1 << n) - 1)) != 0); lat = n + 1; end
    endcase
  endfunction

  // Reference model state, advanced at every rising edge from the bench inputs.
  bit         m_known = 0;
  bit         m_busy  = 0;
  bit         m_valid = 0;
  bit         m_clean = 0;
  int         m_cd    = 0;
  logic [7:0] m_data  = '0;
  logic       m_ovf   = 1'b0;
  logic [2:0] m_op    = '0;

  initial forever begin
    int lat;
    @(posedge clock);
    if (!clear_n) begin
      m_known = 1; m_busy = 0; m_valid = 0; m_clean = 1;
    end else if (m_known) begin
      if (m_valid) begin
        if (bus.rsp_ready) begin m_valid = 0; m_busy = 0; end
      end else if (m_busy) begin
        m_cd--;
        if (m_cd == 0) m_valid = 1;
      end else if (bus.cmd_valid) begin
        model_cmd(bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_cin, m_data, m_ovf, lat);
        m_op = bus.cmd_op; m_busy = 1; m_clean = 0;
        if (lat == 1) m_valid = 1;
        else m_cd = lat - 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge clock);
    if (m_known) begin
      check("cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
      if (m_valid) begin
        check("rsp_data", 32'(bus.rsp_data), 32'(m_data));
        check("rsp_ovf", 32'(bus.rsp_ovf), 32'(m_ovf));
      end
      if (m_busy) check("alu_sel", 32'(bus.alu_sel), 32'(m_op));
      if (m_clean) check("alu_zero", {13'd0, bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_cin}, 32'd0);
    end
  end

  // Directed command with literal expectations for data, flag and latency.
  task automatic run_cmd(input string nm, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic [7:0] ed,
                         input logic eo, input int el);
    int g;
    int lat;
    @(negedge clock);
    bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_cin = cin; bus.cmd_valid = 1'b1;
    g = 0;
    while (!bus.cmd_ready && g < 50) begin @(negedge clock); g++; end
    if (g >= 50) check({nm, " accept_timeout"}, 32'(g), 32'd0);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin @(negedge clock); lat++; end
    check({nm, " latency"}, 32'(lat), 32'(el));
    check({nm, " data"}, 32'(bus.rsp_data), 32'(ed));
    check({nm, " ovf"}, 32'(bus.rsp_ovf), 32'(eo));
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int  g;
    int  hits;
    bit  offered;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.cmd_cin = 1'b0; bus.rsp_ready = 1'b0;
    clear_n = 1'b0;
    repeat (2) @(negedge clock);
    check("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp", {23'd0, bus.rsp_data, bus.rsp_ovf}, 32'd0);
    clear_n = 1'b1;

    run_cmd("add1",   3'd0, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 2);
    run_cmd("addovf", 3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 2);
    run_cmd("addcin", 3'd0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 2);
    run_cmd("sub",    3'd1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 2);
    run_cmd("shl3",   3'd6, 8'h0F, 8'h03, 1'b0, 8'h78, 1'b0, 4);
    run_cmd("shr2",   3'd7, 8'h0F, 8'h02, 1'b0, 8'h03, 1'b1, 3);
    run_cmd("shl0",   3'd6, 8'h0F, 8'h00, 1'b0, 8'h0F, 1'b0, 1);
    run_cmd("shl0hi", 3'd6, 8'h0F, 8'hF8, 1'b0, 8'h0F, 1'b0, 1);
    run_cmd("shl7",   3'd6, 8'h81, 8'h07, 1'b0, 8'h80, 1'b1, 8);
    run_cmd("and",    3'd2, 8'hA0, 8'h2C, 1'b0, 8'h20, 1'b0, 2);
    run_cmd("not",    3'd5, 8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0, 2);

    // Back-pressure: response held while a second command waits.
    @(negedge clock);
    bus.cmd_op = 3'd0; bus.cmd_a = 8'h10; bus.cmd_b = 8'h22; bus.cmd_cin = 1'b0; bus.cmd_valid = 1'b1;
    @(negedge clock);
    bus.cmd_op = 3'd4; bus.cmd_a = 8'h5A; bus.cmd_b = 8'h0F;
    g = 0;
    while (!bus.rsp_valid && g < 20) begin @(negedge clock); g++; end
    for (int i = 0; i < 5; i++) begin
      check("hold cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("hold data", 32'(bus.rsp_data), 32'h32);
      check("hold ovf", 32'(bus.rsp_ovf), 32'd0);
      @(negedge clock);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    check("post-hs cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("post-hs rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    check("second accepted", 32'(bus.cmd_ready), 32'd0);
    g = 1;
    while (!bus.rsp_valid && g < 20) begin @(negedge clock); g++; end
    check("second latency", 32'(g), 32'd2);
    check("second data", 32'(bus.rsp_data), 32'h55);
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;

    // Reset in the middle of a long shift.
    @(negedge clock);
    bus.cmd_op = 3'd6; bus.cmd_a = 8'hFF; bus.cmd_b = 8'h07; bus.cmd_valid = 1'b1;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clock);
    clear_n = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    check("mid-reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid-reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("mid-reset alu", {13'd0, bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_cin}, 32'd0);
    hits = 0;
    repeat (12) begin
      @(negedge clock);
      if (bus.rsp_valid) hits++;
    end
    check("dropped no response", 32'(hits), 32'd0);

    // Randomized traffic; the model checks every cycle.
    offered = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (!bus.cmd_valid || offered) begin
        bus.cmd_valid = ($urandom_range(0, 2) != 0);
        bus.cmd_op    = 3'($urandom);
        bus.cmd_a     = 8'($urandom);
        bus.cmd_b     = 8'($urandom);
        bus.cmd_cin   = 1'($urandom);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      offered = bus.cmd_valid && bus.cmd_ready;
    end
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (20) @(negedge clock);
    check("drain idle", 32'(bus.cmd_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
